wave_integrator: RTL and testbench

WAVE_INTEGRATOR -- requirements
Module: wave_integrator

---
 rtl/wave_integrator.sv | 118 +++++++++++
 tb/tb_wave_integrator.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/wave_integrator.sv
// wave_integrator: rebuilds a waveform from offset first-difference samples.
// A frame opens with a raw seed sample (frame_start). Each later sample is a
// difference d = x[n-1] - x[n] + OFFSET, so x[n] = x[n-1] - (d - OFFSET).
// Results are clamped to the unsigned sample range, and clamping is flagged
// until the next seed. After GAP_MAX idle cycles the frame closes.
module wave_integrator #(
    parameter int FIFO_WIDTH = 8,
    parameter int OFFSET     = 128,
    parameter int GAP_MAX    = 16
) (
    input  logic                  clk_50M,
    input  logic                  rst_n,
    input  logic                  valid,
    input  logic                  frame_start,
    input  logic [FIFO_WIDTH-1:0] diff_data,
    output logic [FIFO_WIDTH-1:0] wave_out,
    output logic                  output_valid,
    output logic                  sat_flag,
    output logic [15:0]           sample_count
);

    // Two guard bits cover the full range acc - (d - OFFSET) without overflow.
    localparam int XW = FIFO_WIDTH + 2;
    localparam int GW = $clog2(GAP_MAX + 1);
    localparam logic signed [XW-1:0] OFFSET_S = XW'(OFFSET);
    localparam logic signed [XW-1:0] MAX_S    = XW'((1 << FIFO_WIDTH) - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [FIFO_WIDTH-1:0]   acc_q, acc_d;
    logic [FIFO_WIDTH-1:0]   wave_q, wave_d;
    logic                    ov_q, ov_d;
    logic                    sat_q, sat_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [GW-1:0]           gap_q, gap_d;

    logic signed [XW-1:0]    x_full;
    logic [FIFO_WIDTH-1:0]   x_clamp;
    logic                    clamped;

    // Integrate one difference sample and clamp it into [0, 2^FIFO_WIDTH-1].
    always_comb begin
        x_full  = $signed({2'b00, acc_q}) - $signed({2'b00, diff_data}) + OFFSET_S;
        x_clamp = x_full[FIFO_WIDTH-1:0];
        clamped = 1'b0;
        if (x_full[XW-1]) begin
            x_clamp = '0;
            clamped = 1'b1;
        end else if (x_full > MAX_S) begin
            x_clamp = '1;
            clamped = 1'b1;
        end
    end

    // Next-state logic: seeding (from either state), integration and gap timeout.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        wave_d  = wave_q;
        ov_d    = 1'b0;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        if (valid && frame_start) begin
            state_d = RUN;
            acc_d   = diff_data;
            wave_d  = diff_data;
            ov_d    = 1'b1;
            sat_d   = 1'b0;
            cnt_d   = 16'd1;
            gap_d   = '0;
        end else if (state_q == RUN) begin
            if (valid) begin
                gap_d  = '0;
                acc_d  = x_clamp;
                wave_d = x_clamp;
                ov_d   = 1'b1;
                if (clamped) sat_d = 1'b1;
                if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            end else if (gap_q == GW'(GAP_MAX - 1)) begin
                // This idle cycle is the GAP_MAX-th in a row: close the frame,
                // leaving wave/sat/count visible until the next seed.
                state_d = IDLE;
                gap_d   = '0;
            end else begin
                gap_d = gap_q + GW'(1);
            end
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            wave_q  <= '0;
            ov_q    <= 1'b0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            wave_q  <= wave_d;
            ov_q    <= ov_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    assign wave_out     = wave_q;
    assign output_valid = ov_q;
    assign sat_flag     = sat_q;
    assign sample_count = cnt_q;

endmodule

// File: tb/tb_wave_integrator.sv
// Bench for wave_integrator: directed vectors feed a queue of expected
// outputs; a monitor pops and compares on every output_valid pulse.
module tb_wave_integrator;

    logic        clk_50M = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        frame_start;
    logic [7:0]  diff_data;
    logic [7:0]  wave_out;
    logic        output_valid;
    logic        sat_flag;
    logic [15:0] sample_count;

    typedef struct {
        logic [7:0]  wave;
        logic        sat;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    wave_integrator #(.FIFO_WIDTH(8), .OFFSET(128), .GAP_MAX(4)) dut (
        .clk_50M     (clk_50M),
        .rst_n       (rst_n),
        .valid       (valid),
        .frame_start (frame_start),
        .diff_data   (diff_data),
        .wave_out    (wave_out),
        .output_valid(output_valid),
        .sat_flag    (sat_flag),
        .sample_count(sample_count)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Monitor: outputs are stable at the falling edge.
    always @(negedge clk_50M) begin
        if (rst_n && output_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got wave=%0d, expected no output", wave_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wave_out", int'(wave_out), int'(e.wave));
                check("sat_flag", int'(sat_flag), int'(e.sat));
                check("sample_count", int'(sample_count), int'(e.cnt));
            end
        end
    end

    // Drive one cycle of input; push the expected output when one is due.
    task automatic drive(input logic v, input logic fs, input logic [7:0] d,
                         input logic push, input logic [7:0] ew,
                         input logic es, input logic [15:0] ec);
        exp_t e;
        @(negedge clk_50M);
        valid       = v;
        frame_start = fs;
        diff_data   = d;
        if (push) begin
            e.wave = ew; e.sat = es; e.cnt = ec;
            exp_q.push_back(e);
        end
    endtask

    task automatic seed(input logic [7:0] d);
        drive(1'b1, 1'b1, d, 1'b1, d, 1'b0, 16'd1);
    endtask

    task automatic diff(input logic [7:0] d, input logic [7:0] ew,
                        input logic es, input logic [15:0] ec);
        drive(1'b1, 1'b0, d, 1'b1, ew, es, ec);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 16'd0);
    endtask

    // One idle cycle, then require that no output is being presented.
    task automatic expect_quiet(input string name);
        idle(1);
        check(name, int'(output_valid), 0);
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; frame_start = 1'b0; diff_data = 8'd0;
        #25;
        check("reset_wave", int'(wave_out), 0);
        check("reset_valid", int'(output_valid), 0);
        check("reset_sat", int'(sat_flag), 0);
        check("reset_count", int'(sample_count), 0);
        @(negedge clk_50M);
        rst_n = 1'b1;

        // Difference before any seed is ignored.
        drive(1'b1, 1'b0, 8'd100, 1'b0, 8'd0, 1'b0, 16'd0);
        expect_quiet("idle_no_seed");

        // Basic reconstruction, back to back.
        seed(8'd100);
        diff(8'd128, 8'd100, 1'b0, 16'd2);
        diff(8'd118, 8'd110, 1'b0, 16'd3);
        diff(8'd138, 8'd100, 1'b0, 16'd4);

        // High clamp, sticky flag (reseed from RUN).
        seed(8'd250);
        diff(8'd100, 8'd255, 1'b1, 16'd2);
        diff(8'd128, 8'd255, 1'b1, 16'd3);

        // Low clamp then reseed clears the flag.
        seed(8'd5);
        diff(8'd200, 8'd0, 1'b1, 16'd2);
        seed(8'd60);

        // Short gap keeps the frame open.
        seed(8'd10);
        idle(3);
        diff(8'd120, 8'd18, 1'b0, 16'd2);

        // Gap timeout closes the frame.
        seed(8'd10);
        idle(4);
        drive(1'b1, 1'b0, 8'd100, 1'b0, 8'd0, 1'b0, 16'd0);
        expect_quiet("gap_timeout_no_output");
        check("held_wave", int'(wave_out), 10);
        check("held_sat", int'(sat_flag), 0);
        check("held_count", int'(sample_count), 1);

        // Reset mid-frame.
        seed(8'd50);
        diff(8'd128, 8'd50, 1'b0, 16'd2);
        idle(1);
        #3 rst_n = 1'b0;
        #1;
        check("midreset_wave", int'(wave_out), 0);
        check("midreset_valid", int'(output_valid), 0);
        check("midreset_sat", int'(sat_flag), 0);
        check("midreset_count", int'(sample_count), 0);
        @(negedge clk_50M);
        @(negedge clk_50M);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 8'd128, 1'b0, 8'd0, 1'b0, 16'd0);
        expect_quiet("post_reset_no_output");

        // A seed after reset works again.
        seed(8'd77);
        diff(8'd130, 8'd75, 1'b0, 16'd2);
        idle(3);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
